// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter sharing one WIDTH-wide 2:1 mux (param_mux) between two
// valid/ready requesters, A and B. The winning word is captured into a
// one-entry output register that the downstream consumer drains with a
// valid/ready handshake.
//
// Optional feature macro: MUX_ARB_STATS_EN
//   Defined   -> CNT_WIDTH parameter plus a_gnt_cnt / b_gnt_cnt saturating
//                accept counters are present.
//   Undefined -> counters, their ports and CNT_WIDTH are absent. Arbitration
//                is identical in both builds.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   a_valid    in   1          requester A has a word
//   a_data     in   WIDTH      requester A word
//   a_ready    out  1          A word accepted when a_valid && a_ready
//   b_valid    in   1          requester B has a word
//   b_data     in   WIDTH      requester B word
//   b_ready    out  1          B word accepted when b_valid && b_ready
//   out_valid  out  1          output register holds a word
//   out_data   out  WIDTH      registered selected word
//   out_src    out  1          source of out_data (0 = A, 1 = B)
//   out_ready  in   1          consumer takes the word when out_valid && out_ready
//   a_gnt_cnt  out  CNT_WIDTH  accepted-A count (MUX_ARB_STATS_EN only)
//   b_gnt_cnt  out  CNT_WIDTH  accepted-B count (MUX_ARB_STATS_EN only)
// -----------------------------------------------------------------------------

// param_mux: plain WIDTH-wide 2:1 multiplexer (i_sel=0 -> i_d0, 1 -> i_d1).
module param_mux #(
  parameter int WIDTH = 4
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_y
);

  // Select one of the two data words.
  always_comb begin
    o_y = {WIDTH{1'b0}};
    case (i_sel)
      1'b0:    o_y = i_d0;
      1'b1:    o_y = i_d1;
      default: o_y = {WIDTH{1'b0}};
    endcase
  end

endmodule

module mux_rr_arbiter #(
  parameter int WIDTH     = 4
`ifdef MUX_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  input  logic [WIDTH-1:0]     a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [WIDTH-1:0]     b_data,
  output logic                 b_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_src,
  input  logic                 out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] a_gnt_cnt,
  output logic [CNT_WIDTH-1:0] b_gnt_cnt
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_last_gnt;   // 1 after reset so A wins the first contention

  logic             w_load_ok;
  logic             w_gnt_valid;
  logic             w_gnt;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_mux_y;

  // The register can take a word if it is empty or is being drained this cycle.
  always_comb begin
    w_load_ok = (!r_out_valid) || out_ready;
  end

  // Grant decision: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = 1'b0;
    case ({a_valid, b_valid})
      2'b10: begin
        w_gnt_valid = 1'b1;
        w_gnt       = 1'b0;
      end
      2'b01: begin
        w_gnt_valid = 1'b1;
        w_gnt       = 1'b1;
      end
      2'b11: begin
        w_gnt_valid = 1'b1;
        w_gnt       = ~r_last_gnt;
      end
      default: begin
        w_gnt_valid = 1'b0;
        w_gnt       = 1'b0;
      end
    endcase
  end

  // Ready generation; the grant is one-hot so both readys can never be high together.
  always_comb begin
    if (w_load_ok && w_gnt_valid) begin
      w_a_ready = (w_gnt == 1'b0) && a_valid;
      w_b_ready = (w_gnt == 1'b1) && b_valid;
    end else begin
      w_a_ready = 1'b0;
      w_b_ready = 1'b0;
    end
    w_accept = w_a_ready || w_b_ready;
  end

  // The shared mux is the only path into the output register; its select is the grant.
  param_mux #(
    .WIDTH (WIDTH)
  ) u_param_mux (
    .i_sel (w_gnt),
    .i_d0  (a_data),
    .i_d1  (b_data),
    .o_y   (w_mux_y)
  );

  // Output register and round-robin pointer; only accepted transfers move the pointer.
  // Requester data is captured only on accept, so X on an idle input stays out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
      r_out_src   <= 1'b0;
      r_last_gnt  <= 1'b1;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_y;
      r_out_src   <= w_gnt;
      r_last_gnt  <= w_gnt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

`ifdef MUX_ARB_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_a_gnt_cnt;
  logic [CNT_WIDTH-1:0] r_b_gnt_cnt;

  // Saturating accept counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_gnt_cnt <= {CNT_WIDTH{1'b0}};
      r_b_gnt_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_a_ready && (r_a_gnt_cnt != CNT_MAX)) begin
        r_a_gnt_cnt <= r_a_gnt_cnt + CNT_ONE;
      end
      if (w_b_ready && (r_b_gnt_cnt != CNT_MAX)) begin
        r_b_gnt_cnt <= r_b_gnt_cnt + CNT_ONE;
      end
    end
  end

  assign a_gnt_cnt = r_a_gnt_cnt;
  assign b_gnt_cnt = r_b_gnt_cnt;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter: table-driven directed vectors, hand-written reset and
// counter sequences, then randomized traffic against a transaction-level
// reference model (a one-slot holding buffer plus a "who was served last" note).
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int W  = 4;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, out_valid, out_src;
  logic [W-1:0] out_data;
`ifdef MUX_ARB_STATS_EN
  logic [CW-1:0] a_gnt_cnt, b_gnt_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

`ifdef MUX_ARB_STATS_EN
  mux_rr_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
`else
  mux_rr_arbiter #(.WIDTH(W)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
    ,
    .a_gnt_cnt (a_gnt_cnt),
    .b_gnt_cnt (b_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  bit         m_full;
  bit [W-1:0] m_data;
  bit         m_src;
  int         m_last_served;   // 0 = A, 1 = B
  int         m_cnt_a, m_cnt_b;
  bit         m_exp_ar, m_exp_br;

  function automatic void model_reset();
    m_full = 1'b0; m_data = '0; m_src = 1'b0;
    m_last_served = 1;         // pretend B went last so A goes first
    m_cnt_a = 0; m_cnt_b = 0;
  endfunction

  function automatic void model_cycle(input bit av, input bit [W-1:0] ad,
                                      input bit bv, input bit [W-1:0] bd,
                                      input bit ordy);
    bit room;
    int pick;
    room = !m_full || ordy;
    pick = -1;
    if (av && bv)  pick = (m_last_served == 0) ? 1 : 0;
    else if (av)   pick = 0;
    else if (bv)   pick = 1;
    m_exp_ar = room && (pick == 0);
    m_exp_br = room && (pick == 1);
    if (m_exp_ar || m_exp_br) begin
      m_full = 1'b1;
      m_data = m_exp_ar ? ad : bd;
      m_src  = m_exp_br;
      m_last_served = pick;
      if (m_exp_ar) m_cnt_a++; else m_cnt_b++;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
  endfunction

  // Drive one cycle at negedge, check readys, clock, check the register against the model.
  task automatic model_step(input string tag, input bit av, input bit [W-1:0] ad,
                            input bit bv, input bit [W-1:0] bd, input bit ordy);
    @(negedge clk);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    model_cycle(av, ad, bv, bd, ordy);
    #1;
    chk({tag, "_readys"}, {30'd0, a_ready, b_ready}, {30'd0, m_exp_ar, m_exp_br});
    @(posedge clk); #1;
    if (m_full)
      chk({tag, "_out"}, {26'd0, out_valid, out_data, out_src}, {26'd0, 1'b1, m_data, m_src});
    else
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         av;
    logic [W-1:0] ad;
    logic         bv;
    logic [W-1:0] bd;
    logic         ordy;
    logic         ar;
    logic         br;
    logic         ov;
    logic [W-1:0] od;
    logic         os;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  initial begin
    //            av    ad     bv    bd     ordy   ar    br    ov    od     os
    tbl[0]  = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0}; // lone A
    tbl[1]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1}; // A served last -> B
    tbl[2]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1};
    tbl[4]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0}; // backpressure
    tbl[6]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1}; // drain + load
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1}; // B only x4
    tbl[10] = '{1'b0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1};
    tbl[13] = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0}; // A after B run
    tbl[14] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0}; // drain, data holds
    tbl[15] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0};
    tbl[16] = '{1'b1, 4'hC, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b0}; // empty loads w/o ready
    tbl[17] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0};
    tbl[18] = '{1'b0, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1}; // A dropped unserved
    tbl[19] = '{1'b1, 4'h7, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    #12;
    // Reset state
    chk("reset_out", {26'd0, out_valid, out_data, out_src}, 32'd0);
`ifdef MUX_ARB_STATS_EN
    chk("reset_cnt", {28'd0, a_gnt_cnt, b_gnt_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_valid = tbl[i].av; a_data = tbl[i].ad; b_valid = tbl[i].bv;
      b_data = tbl[i].bd; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_readys", i), {30'd0, a_ready, b_ready}, {30'd0, tbl[i].ar, tbl[i].br});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i), {26'd0, out_valid, out_data, out_src},
          {26'd0, tbl[i].ov, tbl[i].od, tbl[i].os});
    end

    // Asynchronous reset while the register is full (B was... A was served last)
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", {26'd0, out_valid, out_data, out_src}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 4'h9; b_valid = 1'b1; b_data = 4'h6; out_ready = 1'b1;
    #1;
    chk("post_rst_readys", {30'd0, a_ready, b_ready}, {30'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("post_rst_out", {26'd0, out_valid, out_data, out_src}, {26'd0, 1'b1, 4'h9, 1'b0});

    // Counter saturation sequence: 5 A accepts then 2 B accepts
    do_reset();
    for (int i = 0; i < 5; i++) model_step("cntA", 1'b1, 4'(i + 1), 1'b0, 4'hx, 1'b1);
    for (int i = 0; i < 2; i++) model_step("cntB", 1'b0, 4'hx, 1'b1, 4'(i + 8), 1'b1);
`ifdef MUX_ARB_STATS_EN
    chk("a_gnt_cnt_sat", {30'd0, a_gnt_cnt}, 32'd3);
    chk("b_gnt_cnt", {30'd0, b_gnt_cnt}, 32'd2);
    chk("model_cnt_a", {30'd0, a_gnt_cnt}, (m_cnt_a > 3) ? 32'd3 : 32'(m_cnt_a));
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit av, bv, ordy;
      bit [W-1:0] ad, bd;
      av   = ($urandom_range(0, 3) != 0);
      bv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      ad   = W'($urandom);
      bd   = W'($urandom);
      model_step("rand", av, ad, bv, bd, ordy);
    end
`ifdef MUX_ARB_STATS_EN
    chk("rand_cnt", {28'd0, a_gnt_cnt, b_gnt_cnt},
        {28'd0, (m_cnt_a > 3) ? 2'd3 : 2'(m_cnt_a), (m_cnt_b > 3) ? 2'd3 : 2'(m_cnt_b)});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
